// File: rtl/pipe_pkg.sv
// Shared pipeline encodings: write-back selects, hazard FSM states and stage control bundle.
package pipe_pkg;

   localparam int unsigned REG_W   = 5;
   localparam int unsigned WBSEL_W = 2;

   localparam logic [REG_W-1:0]   REG_ZERO = REG_W'(0);

   localparam logic [WBSEL_W-1:0] WB_ALU = 2'b00;
   localparam logic [WBSEL_W-1:0] WB_MEM = 2'b01;
   localparam logic [WBSEL_W-1:0] WB_PC4 = 2'b10;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_ABORT    = 2'd2
   } hz_state_e;

   // Hold/bubble controls for the pipeline registers, one field per control wire.
   typedef struct packed {
      logic pc_stall;
      logic ifid_stall;
      logic ifid_flush;
      logic idex_stall;
      logic idex_flush;
      logic exmem_stall;
      logic exmem_flush;
      logic memwb_flush;
   } pipe_ctrl_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use compare between the instruction in ID and a load sitting in EX.
module hazard_detect
   import pipe_pkg::*;
(
   input  logic [REG_W-1:0]   id_rs1_id,
   input  logic [REG_W-1:0]   id_rs2_id,
   input  logic               id_use_rs1,
   input  logic               id_use_rs2,
   input  logic [REG_W-1:0]   ex_rdst_id,
   input  logic               ex_we_reg,
   input  logic [WBSEL_W-1:0] ex_wbsel,
   output logic               load_use_c
);

   logic ex_is_load;
   logic rs1_hit;
   logic rs2_hit;

   always_comb begin
      ex_is_load = ex_we_reg & (ex_wbsel == WB_MEM) & (ex_rdst_id != REG_ZERO);
      rs1_hit    = id_use_rs1 & (id_rs1_id == ex_rdst_id);
      rs2_hit    = id_use_rs2 & (id_rs2_id == ex_rdst_id);
      load_use_c = ex_is_load & (rs1_hit | rs2_hit);
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, EX redirect flushes, data-memory wait
// with timeout abort. Define HAZARD_PERF_EN to add saturating stall/flush/load-use counters.
module hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned TO_W        = 8,
   parameter int unsigned CNT_W       = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [REG_W-1:0]   id_rs1_id,
   input  logic [REG_W-1:0]   id_rs2_id,
   input  logic               id_use_rs1,
   input  logic               id_use_rs2,
   input  logic [REG_W-1:0]   ex_rdst_id,
   input  logic               ex_we_reg,
   input  logic [WBSEL_W-1:0] ex_wbsel,
   input  logic               ex_branch_taken,
   input  logic               mem_req,
   input  logic               dmem_ready,
   output logic               pc_stall,
   output logic               ifid_stall,
   output logic               ifid_flush,
   output logic               idex_stall,
   output logic               idex_flush,
   output logic               exmem_stall,
   output logic               exmem_flush,
   output logic               memwb_flush,
   output logic               mem_err,
   output logic [1:0]         state_o
`ifdef HAZARD_PERF_EN
   ,
   output logic [CNT_W-1:0]   stall_cnt,
   output logic [CNT_W-1:0]   flush_cnt,
   output logic [CNT_W-1:0]   ldu_cnt
`endif
);

   if (MEM_TIMEOUT == 0 || MEM_TIMEOUT > 255 || MEM_TIMEOUT > (2**TO_W - 1) || CNT_W == 0)
   begin : g_bad_cfg
      $error("hazard_ctrl: MEM_TIMEOUT must be 1..255 and fit in TO_W; CNT_W must be nonzero");
   end

   hz_state_e        state;
   hz_state_e        state_nx;
   logic [TO_W-1:0]  wait_cnt;
   logic [TO_W-1:0]  cnt_nx;
   logic             load_use_c;
   logic             mem_stall_c;
   logic             run_act_c;
   pipe_ctrl_t       run_ctrl_c;
   pipe_ctrl_t       ctrl_c;

   hazard_detect u_detect (
      .id_rs1_id  (id_rs1_id),
      .id_rs2_id  (id_rs2_id),
      .id_use_rs1 (id_use_rs1),
      .id_use_rs2 (id_use_rs2),
      .ex_rdst_id (ex_rdst_id),
      .ex_we_reg  (ex_we_reg),
      .ex_wbsel   (ex_wbsel),
      .load_use_c (load_use_c)
   );

   // Decode used whenever memory is not holding the pipe: redirect beats load-use.
   always_comb begin
      run_ctrl_c = '0;
      if (ex_branch_taken) begin
         run_ctrl_c.ifid_flush = 1'b1;
         run_ctrl_c.idex_flush = 1'b1;
      end else if (load_use_c) begin
         run_ctrl_c.pc_stall   = 1'b1;
         run_ctrl_c.ifid_stall = 1'b1;
         run_ctrl_c.idex_flush = 1'b1;
      end
   end

   // Next-state and Mealy control decode.
   always_comb begin
      ctrl_c      = '0;
      state_nx    = state;
      cnt_nx      = wait_cnt;
      run_act_c   = 1'b0;
      mem_stall_c = mem_req & ~dmem_ready;

      case (state)
         ST_RUN, ST_MEM_WAIT: begin
            if (mem_stall_c) begin
               ctrl_c.pc_stall    = 1'b1;
               ctrl_c.ifid_stall  = 1'b1;
               ctrl_c.idex_stall  = 1'b1;
               ctrl_c.exmem_stall = 1'b1;
               ctrl_c.memwb_flush = 1'b1;
               if (state == ST_RUN) begin
                  state_nx = ST_MEM_WAIT;
                  cnt_nx   = TO_W'(1);
               end else if (wait_cnt == TO_W'(MEM_TIMEOUT)) begin
                  state_nx = ST_ABORT;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx   = wait_cnt + TO_W'(1);
               end
            end else begin
               // Frozen branch/load-use hazards are re-evaluated on the release cycle.
               ctrl_c    = run_ctrl_c;
               run_act_c = 1'b1;
               state_nx  = ST_RUN;
               cnt_nx    = '0;
            end
         end
         ST_ABORT: begin
            ctrl_c.pc_stall    = 1'b1;
            ctrl_c.ifid_flush  = 1'b1;
            ctrl_c.idex_flush  = 1'b1;
            ctrl_c.exmem_flush = 1'b1;
            ctrl_c.memwb_flush = 1'b1;
            state_nx           = ST_RUN;
            cnt_nx             = '0;
         end
         default: begin
            state_nx = ST_RUN;
            cnt_nx   = '0;
         end
      endcase

      if (!rst) begin
         ctrl_c    = '0;
         run_act_c = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_RUN;
         wait_cnt <= '0;
         mem_err  <= 1'b0;
      end else begin
         state    <= state_nx;
         wait_cnt <= cnt_nx;
         if (state_nx == ST_ABORT) begin
            mem_err <= 1'b1;
         end
      end
   end

   assign pc_stall    = ctrl_c.pc_stall;
   assign ifid_stall  = ctrl_c.ifid_stall;
   assign ifid_flush  = ctrl_c.ifid_flush;
   assign idex_stall  = ctrl_c.idex_stall;
   assign idex_flush  = ctrl_c.idex_flush;
   assign exmem_stall = ctrl_c.exmem_stall;
   assign exmem_flush = ctrl_c.exmem_flush;
   assign memwb_flush = ctrl_c.memwb_flush;
   assign state_o     = state;

`ifdef HAZARD_PERF_EN
   // Saturating event counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
         ldu_cnt   <= '0;
      end else begin
         if (ctrl_c.pc_stall && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
         if (run_act_c && ex_branch_taken && flush_cnt != '1) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
         end
         if (run_act_c && !ex_branch_taken && load_use_c && ldu_cnt != '1) begin
            ldu_cnt <= ldu_cnt + CNT_W'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic against a
// behavioural model that counts consecutive memory-stall cycles.
module tb_hazard_ctrl;
   import pipe_pkg::*;

   localparam int unsigned TO = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [4:0] id_rs1_id, id_rs2_id, ex_rdst_id;
   logic       id_use_rs1, id_use_rs2, ex_we_reg, ex_branch_taken, mem_req, dmem_ready;
   logic [1:0] ex_wbsel;
   logic       pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
   logic       exmem_stall, exmem_flush, memwb_flush, mem_err;
   logic [1:0] state_o;
`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cnt, flush_cnt, ldu_cnt;
`endif

   always #5 clk = ~clk;

   hazard_ctrl #(.MEM_TIMEOUT(TO), .TO_W(8), .CNT_W(32)) dut (
      .clk             (clk),
      .rst             (rst),
      .id_rs1_id       (id_rs1_id),
      .id_rs2_id       (id_rs2_id),
      .id_use_rs1      (id_use_rs1),
      .id_use_rs2      (id_use_rs2),
      .ex_rdst_id      (ex_rdst_id),
      .ex_we_reg       (ex_we_reg),
      .ex_wbsel        (ex_wbsel),
      .ex_branch_taken (ex_branch_taken),
      .mem_req         (mem_req),
      .dmem_ready      (dmem_ready),
      .pc_stall        (pc_stall),
      .ifid_stall      (ifid_stall),
      .ifid_flush      (ifid_flush),
      .idex_stall      (idex_stall),
      .idex_flush      (idex_flush),
      .exmem_stall     (exmem_stall),
      .exmem_flush     (exmem_flush),
      .memwb_flush     (memwb_flush),
      .mem_err         (mem_err),
      .state_o         (state_o)
`ifdef HAZARD_PERF_EN
      ,
      .stall_cnt       (stall_cnt),
      .flush_cnt       (flush_cnt),
      .ldu_cnt         (ldu_cnt)
`endif
   );

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   // Model: length of the current run of stalled cycles, pending abort, sticky error.
   int      m_wait;
   bit      m_abort;
   bit      m_err;
   longint  m_stall_n, m_flush_n, m_ldu_n;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] outs();
      return {pc_stall, ifid_stall, ifid_flush, idex_stall,
              idex_flush, exmem_stall, exmem_flush, memwb_flush};
   endfunction

   function automatic bit ref_load_use();
      bit hit1, hit2;
      hit1 = id_use_rs1 && (id_rs1_id == ex_rdst_id);
      hit2 = id_use_rs2 && (id_rs2_id == ex_rdst_id);
      return ex_we_reg && (ex_wbsel == 2'b01) && (ex_rdst_id != 5'd0) && (hit1 || hit2);
   endfunction

   task automatic model_reset();
      m_wait = 0; m_abort = 0; m_err = 0;
      m_stall_n = 0; m_flush_n = 0; m_ldu_n = 0;
   endtask

   // Compare process: expected outputs from the hazard rules, then advance the model.
   always @(negedge clk) begin
      if (chk_en) begin
         bit         ms, lu, br_ev, lu_ev;
         logic [7:0] ev;
         logic [1:0] es;
         ms = mem_req && !dmem_ready;
         lu = ref_load_use();
         br_ev = 0; lu_ev = 0;
         if (m_abort) begin
            ev = 8'b1010_1011;  es = 2'd2;
         end else if (ms) begin
            ev = 8'b1101_0101;  es = (m_wait > 0) ? 2'd1 : 2'd0;
         end else begin
            es = (m_wait > 0) ? 2'd1 : 2'd0;
            if (ex_branch_taken) begin ev = 8'b0010_1000; br_ev = 1; end
            else if (lu)         begin ev = 8'b1100_1000; lu_ev = 1; end
            else                       ev = 8'b0000_0000;
         end
         check("ctrl_outputs", 64'(outs()), 64'(ev));
         check("state_o", 64'(state_o), 64'(es));
         check("mem_err", 64'(mem_err), 64'(m_err));
`ifdef HAZARD_PERF_EN
         check("stall_cnt", 64'(stall_cnt), 64'(m_stall_n));
         check("flush_cnt", 64'(flush_cnt), 64'(m_flush_n));
         check("ldu_cnt", 64'(ldu_cnt), 64'(m_ldu_n));
`endif
         if (ev[7]) m_stall_n++;
         if (br_ev) m_flush_n++;
         if (lu_ev) m_ldu_n++;
         if (m_abort) begin
            m_abort = 0; m_wait = 0;
         end else if (ms) begin
            m_wait++;
            if (m_wait > int'(TO)) begin m_abort = 1; m_err = 1; m_wait = 0; end
         end else begin
            m_wait = 0;
         end
      end
   end

   task automatic clear_in();
      id_rs1_id = 0; id_rs2_id = 0; ex_rdst_id = 0;
      id_use_rs1 = 0; id_use_rs2 = 0; ex_we_reg = 0; ex_wbsel = 0;
      ex_branch_taken = 0; mem_req = 0; dmem_ready = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_load_use(input logic [4:0] rd);
      ex_we_reg = 1; ex_wbsel = WB_MEM; ex_rdst_id = rd;
      id_rs1_id = 5'd5; id_use_rs1 = 1;
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
      chk_en = 1'b1;
   endtask

   initial begin
      clear_in();
      model_reset();
      // Outputs forced low while reset is held, even with a memory stall present.
      mem_req = 1; dmem_ready = 0;
      #3;
      check("reset_pc_stall", 64'(pc_stall), 64'd0);
      check("reset_outputs", 64'(outs()), 64'd0);
      check("reset_state", 64'(state_o), 64'd0);
      check("reset_mem_err", 64'(mem_err), 64'd0);
      clear_in();
      release_reset();

      // Load-use: one bubble cycle, then none once the hazard is gone.
      set_load_use(5'd5);
      #1;
      check("ldu_bubble", 64'({pc_stall, ifid_stall, idex_flush, idex_stall}), 64'b1110);
      step();
      clear_in();
      #1;
      check("ldu_one_cycle", 64'(pc_stall), 64'd0);
      step();
      set_load_use(5'd0);
      #1;
      check("ldu_x0_no_stall", 64'(outs()), 64'd0);
      step();

      // Redirect wins over a coincident load-use.
      set_load_use(5'd5);
      ex_branch_taken = 1;
      #1;
      check("branch_flush", 64'({ifid_flush, idex_flush, pc_stall, ifid_stall}), 64'b1100);
      step();
      clear_in();
      #1;
      check("branch_state_run", 64'(state_o), 64'd0);
      step();

      // Memory wait: three stalled cycles, then release.
      mem_req = 1; dmem_ready = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("wait_stall", 64'({pc_stall, exmem_stall, memwb_flush}), 64'b111);
         step();
      end
      dmem_ready = 1;
      #1;
      check("wait_release", 64'(outs()), 64'd0);
      check("wait_release_state", 64'(state_o), 64'd1);
      step();
      clear_in();
      #1;
      check("wait_back_run", 64'(state_o), 64'd0);
      step();

      // Timeout: one entry cycle plus TO MEM_WAIT cycles, then a single ABORT.
      mem_req = 1; dmem_ready = 0;
      for (int i = 0; i < int'(TO) + 1; i++) step();
      #1;
      check("abort_state", 64'(state_o), 64'd2);
      check("abort_outputs", 64'(outs()), 64'b1010_1011);
      check("abort_mem_err", 64'(mem_err), 64'd1);
      step();
      clear_in();
      #1;
      check("after_abort_state", 64'(state_o), 64'd0);
      check("mem_err_sticky", 64'(mem_err), 64'd1);
      step();

      // Asynchronous reset in the middle of a memory wait.
      mem_req = 1; dmem_ready = 0;
      step(); step();
      #1;
      check("pre_reset_waiting", 64'(state_o), 64'd1);
      chk_en = 1'b0;
      rst = 1'b0;
      #1;
      check("async_rst_outputs", 64'(outs()), 64'd0);
      check("async_rst_state", 64'(state_o), 64'd0);
      check("async_rst_mem_err", 64'(mem_err), 64'd0);
      clear_in();
      release_reset();
      #1;
      check("post_rst_state", 64'(state_o), 64'd0);
      check("post_rst_mem_err", 64'(mem_err), 64'd0);
      step();

      // Counter scenario: two load-use bubbles, one redirect, a three-cycle wait.
      set_load_use(5'd5); step(); clear_in(); step();
      set_load_use(5'd5); step(); clear_in(); step();
      ex_branch_taken = 1; step(); clear_in(); step();
      mem_req = 1; dmem_ready = 0;
      step(); step(); step();
      dmem_ready = 1; step();
      clear_in(); step();
`ifdef HAZARD_PERF_EN
      check("perf_ldu", 64'(ldu_cnt), 64'd2);
      check("perf_flush", 64'(flush_cnt), 64'd1);
      check("perf_stall", 64'(stall_cnt), 64'd5);
`endif

      // Randomized traffic with small register ids so hazards are frequent.
      for (int i = 0; i < 3000; i++) begin
         id_rs1_id       = 5'($urandom_range(0, 3));
         id_rs2_id       = 5'($urandom_range(0, 3));
         ex_rdst_id      = 5'($urandom_range(0, 3));
         id_use_rs1      = 1'($urandom_range(0, 1));
         id_use_rs2      = 1'($urandom_range(0, 1));
         ex_we_reg       = 1'($urandom_range(0, 1));
         ex_wbsel        = 2'($urandom_range(0, 2));
         ex_branch_taken = ($urandom_range(0, 5) == 0);
         mem_req         = 1'($urandom_range(0, 1));
         dmem_ready      = ($urandom_range(0, 9) < 3);
         step();
      end

      clear_in();
      step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
